// File: rtl/relogio_seq_ctrl_if.sv
// Bus between the clock sequencer and the six BCD digit counters.
// Carries the tick and button inputs, the digit feedback, and the strobe outputs.
interface relogio_seq_ctrl_if;
  localparam int unsigned DIGITS = 6;
  localparam int unsigned Q_W    = 4;
  localparam int unsigned MODE_W = 2;

  logic              tick_in;
  logic              btn_mode;
  logic              btn_inc;
  logic [Q_W-1:0]    q_su;
  logic [Q_W-1:0]    q_st;
  logic [Q_W-1:0]    q_mu;
  logic [Q_W-1:0]    q_mt;
  logic [Q_W-1:0]    q_hu;
  logic [Q_W-1:0]    q_ht;
  logic [DIGITS-1:0] cnt_en;
  logic [DIGITS-1:0] cnt_clr;
  logic [MODE_W-1:0] mode;
  logic              blink;

  // Driver side: timebase, buttons and counter feedback.
  modport master (
    output tick_in, btn_mode, btn_inc,
    output q_su, q_st, q_mu, q_mt, q_hu, q_ht,
    input  cnt_en, cnt_clr, mode, blink
  );

  // Sequencer side.
  modport slave (
    input  tick_in, btn_mode, btn_inc,
    input  q_su, q_st, q_mu, q_mt, q_hu, q_ht,
    output cnt_en, cnt_clr, mode, blink
  );
endinterface

// File: rtl/relogio_seq_ctrl.sv
// Digital clock sequencer: turns timebase ticks and button presses into
// count-enable / synchronous-clear strobes for six BCD digit counters,
// implementing the carry chain and the RUN / SET_H / SET_M mode machine.
// Digit values are never stored here; the counters are read back as feedback.
module relogio_seq_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic              clk,
  input  logic              rst,
  relogio_seq_ctrl_if.slave bus
);

  localparam int unsigned PRE_W  = 10;
  localparam int unsigned DIGITS = 6;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } modeT;

  modeT              modeQ;
  logic [PRE_W-1:0]  prescaler;
  logic              prevMode;
  logic              prevInc;
  logic              pendSec;
  logic              pendMode;
  logic              pendInc;
  logic [DIGITS-1:0] cntEnQ;
  logic [DIGITS-1:0] cntClrQ;
  logic              blinkQ;

  logic secNow;
  logic modeNow;
  logic incNow;
  logic busy;
  logic secEv;
  logic modeEv;
  logic incEv;

  logic suMax;
  logic stMax;
  logic muMax;
  logic mtMax;
  logic huMax;
  logic hoursWrap;

  logic [1:0]        hrEn;
  logic [1:0]        hrClr;
  logic [1:0]        minEn;
  logic [1:0]        minClr;
  logic [DIGITS-1:0] runEn;
  logic [DIGITS-1:0] runClr;

  // Raw events seen at this edge.
  assign secNow  = bus.tick_in && (prescaler == PRE_LAST);
  assign modeNow = bus.btn_mode && !prevMode;
  assign incNow  = bus.btn_inc && !prevInc;

  // Feedback is stale while last cycle's strobe is still being applied.
  assign busy = (|cntEnQ) || (|cntClrQ);

  // Events serviced at this edge; a mode press swallows a coincident inc press.
  assign secEv  = !busy && (secNow || pendSec);
  assign modeEv = !busy && (modeNow || pendMode);
  assign incEv  = !busy && (incNow || pendInc) && !modeEv;

  // Out-of-range digits count as at-max so the clock always recovers.
  assign suMax     = bus.q_su >= 4'd9;
  assign stMax     = bus.q_st >= 4'd5;
  assign muMax     = bus.q_mu >= 4'd9;
  assign mtMax     = bus.q_mt >= 4'd5;
  assign huMax     = bus.q_hu >= 4'd9;
  assign hoursWrap = (bus.q_ht > 4'd2) || ((bus.q_ht == 4'd2) && (bus.q_hu >= 4'd3));

  // Hours pair advance: 23 -> 00, x9 -> (x+1)0, otherwise bump units.
  always_comb begin : hoursAdvance
    hrEn  = 2'b00;
    hrClr = 2'b00;
    if (hoursWrap) begin
      hrClr = 2'b11;
    end else if (huMax) begin
      hrClr = 2'b01;
      hrEn  = 2'b10;
    end else begin
      hrEn = 2'b01;
    end
  end

  // Minutes pair advance used in SET_M; wraps 59 -> 00 without touching hours.
  always_comb begin : minutesAdvance
    minEn  = 2'b00;
    minClr = 2'b00;
    if (!muMax) begin
      minEn[0] = 1'b1;
    end else begin
      minClr[0] = 1'b1;
      if (!mtMax) begin
        minEn[1] = 1'b1;
      end else begin
        minClr[1] = 1'b1;
      end
    end
  end

  // Full ripple from seconds units through the hours pair.
  always_comb begin : runChain
    runEn  = '0;
    runClr = '0;
    if (!suMax) begin
      runEn[0] = 1'b1;
    end else begin
      runClr[0] = 1'b1;
      if (!stMax) begin
        runEn[1] = 1'b1;
      end else begin
        runClr[1] = 1'b1;
        if (!muMax) begin
          runEn[2] = 1'b1;
        end else begin
          runClr[2] = 1'b1;
          if (!mtMax) begin
            runEn[3] = 1'b1;
          end else begin
            runClr[3]   = 1'b1;
            runEn[5:4]  = hrEn;
            runClr[5:4] = hrClr;
          end
        end
      end
    end
  end

  // Prescaler, button history, pending flags and the mode machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modeQ     <= RUN;
      prescaler <= '0;
      prevMode  <= 1'b0;
      prevInc   <= 1'b0;
      pendSec   <= 1'b0;
      pendMode  <= 1'b0;
      pendInc   <= 1'b0;
      cntEnQ    <= '0;
      cntClrQ   <= '0;
      blinkQ    <= 1'b0;
    end else begin
      prevMode <= bus.btn_mode;
      prevInc  <= bus.btn_inc;
      cntEnQ   <= '0;
      cntClrQ  <= '0;

      if (modeEv && (modeQ == SET_M)) begin
        prescaler <= '0;
      end else if (bus.tick_in) begin
        prescaler <= secNow ? '0 : prescaler + PRE_W'(1);
      end

      if (busy) begin
        pendSec  <= pendSec  || secNow;
        pendMode <= pendMode || modeNow;
        pendInc  <= pendInc  || incNow;
      end else begin
        pendSec  <= 1'b0;
        pendMode <= 1'b0;
        pendInc  <= 1'b0;
      end

      case (modeQ)
        RUN: begin
          blinkQ <= 1'b0;
          if (secEv) begin
            cntEnQ  <= runEn;
            cntClrQ <= runClr;
          end
          if (modeEv) begin
            modeQ <= SET_H;
          end
        end
        SET_H: begin
          if (secEv) begin
            blinkQ <= !blinkQ;
          end
          if (modeEv) begin
            modeQ <= SET_M;
          end else if (incEv) begin
            cntEnQ  <= {hrEn, 4'b0000};
            cntClrQ <= {hrClr, 4'b0000};
          end
        end
        SET_M: begin
          if (modeEv) begin
            modeQ   <= RUN;
            blinkQ  <= 1'b0;
            cntClrQ <= 6'b000011;
          end else begin
            if (secEv) begin
              blinkQ <= !blinkQ;
            end
            if (incEv) begin
              cntEnQ  <= {2'b00, minEn, 2'b00};
              cntClrQ <= {2'b00, minClr, 2'b00};
            end
          end
        end
        default: begin
          modeQ  <= RUN;
          blinkQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt_en  = cntEnQ;
  assign bus.cnt_clr = cntClrQ;
  assign bus.mode    = modeQ;
  assign bus.blink   = blinkQ;

endmodule

// File: doc/relogio_seq_ctrl.md
Name: relogio_seq_ctrl

Overview:
- Sequencing controller for the six BCD digit counters of the digital clock: seconds units/tens, minutes units/tens, hours units/tens.
- Turns a timebase tick and two debounced user buttons into per-counter count-enable and synchronous-clear strobes.
- Implements the carry chain and the run/set-time mode state machine.
- Reads each counter's current value back as feedback; holds no time digits itself.

Parameters:
TICKS_PER_SEC, 1, tick_in pulses per one-second advance (1..1023); internal prescaler width 10 bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
tick_in  input  1  one-clk timebase pulse
btn_mode  input  1  debounced, clk-synchronous level; rising edge = mode press
btn_inc  input  1  debounced, clk-synchronous level; rising edge = increment press
q_su  input  4  seconds units feedback (0-9)
q_st  input  4  seconds tens feedback (0-5)
q_mu  input  4  minutes units feedback (0-9)
q_mt  input  4  minutes tens feedback (0-5)
q_hu  input  4  hours units feedback (0-9)
q_ht  input  4  hours tens feedback (0-2)
cnt_en  output  6  count-enable strobes; bit order [0]=su,[1]=st,[2]=mu,[3]=mt,[4]=hu,[5]=ht
cnt_clr  output  6  synchronous-clear strobes, same bit order
mode  output  2  00 RUN, 01 SET_H, 10 SET_M
blink  output  1  display blink flag for digits being set

Behaviour:
Reset:
- rst high forces mode=RUN, cnt_en=0, cnt_clr=0, blink=0.
- Prescaler=0; button history regs=0; pending flags=0.
- Reset mid-operation aborts any pending event.

Outputs and strobe rules:
- All outputs are registered.
- Strobes last exactly one clk.
- cnt_en[i] and cnt_clr[i] are never both 1.

Event detection:
- btn edge = btn=1 at this edge and 0 at the previous edge.
- Second event = tick_in accepted while prescaler==TICKS_PER_SEC-1; the prescaler then wraps to 0, otherwise it increments.
- An event sampled at edge N produces strobes valid in cycle N..N+1.

Feedback hazard:
- If any strobe was driven in the previous cycle, an event is held in a one-deep pending flag per source (sec, mode, inc).
- A held event is serviced at the next edge.
- A second same-source event arriving while one is pending is dropped.

Advance(i), applied to digit i:
- max(su,mu)=9; max(st,mt)=5.
- If q_i==max_i: clr[i]=1, then Advance(i+1). Otherwise: en[i]=1.

Hours pair advance:
- If q_ht==2 and q_hu==3: clr[4]=clr[5]=1.
- Else if q_hu==9: clr[4]=1, en[5]=1.
- Else: en[4]=1.

State machine (mode), on a mode press:
- RUN→SET_H→SET_M→RUN.
- SET_M→RUN also drives clr[0]=clr[1]=1 and resets the prescaler.
- Mode press and inc press in the same cycle: mode wins, inc is dropped.

RUN:
- Second event: Advance(su), rippling through the full chain up to 23:59:59→00:00:00.
- Inc press is ignored.

SET_H:
- Inc press: hours pair advance only; 23→00, no carry.
- Second events are consumed by the prescaler but generate no strobes.

SET_M:
- Inc press: Advance(mu), stopping at mt; 59→00 clears mu and mt, with no carry into hours.

Simultaneous events in RUN:
- Second event and mode press in the same cycle: time advance strobes are issued and the mode changes at that edge.

blink:
- Toggles on each second event in SET_H/SET_M.
- Forced to 0 in RUN.

Out-of-range feedback (e.g. q_su>9, q_hu>3 with q_ht==2):
- Treated as at-max: clears and carries. This guarantees recovery.

Test Plan:
1. TICKS_PER_SEC=4, RUN, q=00:00:08, 4 tick_in → single strobe en=000001 one clk after the 4th tick; no strobe on ticks 1-3.
2. RUN, q=12:59:59, second event → clr=001111, en=010000, same cycle.
3. RUN, q=23:59:59, second event → clr=111111, en=000000; mode stays 00.
4. Mode press ×1, q_h=23, inc press → mode=01, clr=110000; a tick during SET_H gives no strobe; blink toggles.
5. SET_M, q_m=59, inc press → clr=001100, en=000000; mode press → mode=00 with clr=000011 and prescaler=0.
6. Inc press the cycle after a strobe → serviced one cycle later; mode+inc same cycle → only mode change; rst asserted mid-SET_M → mode=00, outputs 0 immediately.
